// File: rtl/phase_sequencer_if.sv
// Control inputs and lamp/status outputs of the phase sequencer.
// master drives demand and mode; slave is the sequencer itself.
interface phase_sequencer_if;
  logic       tick;
  logic       req1;
  logic       req2;
  logic       ped_req;
  logic       manual;
  logic       man_sel;
  logic       D1;
  logic       V1;
  logic       X1;
  logic       D2;
  logic       V2;
  logic       X2;
  logic [4:0] cnt;
  logic [2:0] phase;
  logic       ped_walk;

  modport master (
    output tick, req1, req2, ped_req,
    output manual, man_sel,
    input  D1, V1, X1, D2, V2, X2,
    input  cnt, phase, ped_walk
  );

  modport slave (
    input  tick, req1, req2, ped_req,
    input  manual, man_sel,
    output D1, V1, X1, D2, V2, X2,
    output cnt, phase, ped_walk
  );
endinterface

// File: rtl/phase_sequencer.sv
// Two-line traffic phase sequencer: min/max green, yellow, clearance,
// manual override; pedestrian WALK phase when PED_PHASE_EN is defined.
module phase_sequencer #(
  parameter int T_GMIN = 5,
  parameter int T_GMAX = 22,
  parameter int T_YEL  = 2,
  parameter int T_CLR  = 1,
  parameter int T_WALK = 6
) (
  input logic              clk,
  input logic              reset,
  phase_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    G1   = 3'd0,
    Y1   = 3'd1,
    C1   = 3'd2,
    G2   = 3'd3,
    Y2   = 3'd4,
    C2   = 3'd5,
    WALK = 3'd6
  } state_t;

  localparam logic [4:0] LGMAX = 5'(T_GMAX);
  localparam logic [4:0] LYEL  = 5'(T_YEL);
  localparam logic [4:0] LCLR  = 5'(T_CLR);
  localparam logic [4:0] LWALK = 5'(T_WALK);
  localparam logic [5:0] LGMIN = 6'(T_GMIN);

  // lamp vector order: {D1,V1,X1,D2,V2,X2}
  localparam logic [5:0] LMP_G1 = 6'b001100;
  localparam logic [5:0] LMP_Y1 = 6'b010100;
  localparam logic [5:0] LMP_G2 = 6'b100001;
  localparam logic [5:0] LMP_Y2 = 6'b100010;
  localparam logic [5:0] LMP_RR = 6'b100100;

  function automatic logic [4:0] load_f(input state_t s);
    case (s)
      G1, G2:  load_f = LGMAX;
      Y1, Y2:  load_f = LYEL;
      C1, C2:  load_f = LCLR;
      default: load_f = LWALK;
    endcase
  endfunction

  function automatic logic [5:0] lamp_f(input state_t s);
    case (s)
      G1:      lamp_f = LMP_G1;
      Y1:      lamp_f = LMP_Y1;
      G2:      lamp_f = LMP_G2;
      Y2:      lamp_f = LMP_Y2;
      default: lamp_f = LMP_RR;
    endcase
  endfunction

  state_t     st_q;
  state_t     st_d;
  logic [4:0] tmr_q;
  logic [4:0] tmr_d;
  logic [4:0] cnt_q;
  logic [4:0] cnt_d;
  logic [5:0] lmp_q;
  logic       lg_q;
  logic       lg_d;
  logic       pend_q;
  logic       pend_d;
  logic       walk_q;
  logic       green;
  logic       line;
  logic       opp;
  logic       ped_now;
  logic       hold;
  logic       hold_n;
  logic [5:0] el;

  assign green = (st_q == G1) || (st_q == G2);
  assign line  = (st_q == G2);
  assign opp   = line ? bus.req1 : bus.req2;
  assign hold  = bus.manual && green &&
                 (bus.man_sel == line);
  assign el    = 6'(LGMAX) - {1'b0, tmr_q} + 6'd1;

`ifdef PED_PHASE_EN
  // a request arriving on the deciding cycle still counts
  assign ped_now = pend_q | bus.ped_req;
  assign pend_d  = bus.ped_req |
                   (pend_q & ~((st_d == WALK) &&
                               (st_q != WALK)));
`else
  logic unused_ped;
  assign unused_ped = bus.ped_req;
  assign ped_now    = pend_q;
  assign pend_d     = 1'b0;
`endif

  always_comb begin
    st_d  = st_q;
    tmr_d = tmr_q;
    lg_d  = lg_q;
    if (bus.tick) begin
      if (tmr_q > 5'd1) tmr_d = tmr_q - 5'd1;
      unique case (st_q)
        G1, G2: begin
          if (bus.manual) begin
            if (!hold) st_d = line ? Y2 : Y1;
          end else if (el >= LGMIN &&
                       (opp || ped_now)) begin
            st_d = line ? Y2 : Y1;
          end
        end
        Y1: if (tmr_q == 5'd1) st_d = C1;
        Y2: if (tmr_q == 5'd1) st_d = C2;
        C1, C2: begin
          if (tmr_q == 5'd1) begin
            if (bus.manual)
              st_d = bus.man_sel ? G2 : G1;
            else if (ped_now)
              st_d = WALK;
            else
              st_d = (st_q == C1) ? G2 : G1;
          end
        end
        WALK: if (tmr_q == 5'd1) st_d = lg_q ? G1 : G2;
        default: st_d = G1;
      endcase
    end
    if (st_d != st_q) tmr_d = load_f(st_d);
    // a manually held green keeps its full budget for later
    if (hold) tmr_d = LGMAX;
    if (st_d == G1) lg_d = 1'b0;
    else if (st_d == G2) lg_d = 1'b1;
  end

  assign hold_n = bus.manual &&
                  ((st_d == G1 && !bus.man_sel) ||
                   (st_d == G2 && bus.man_sel));
  assign cnt_d  = hold_n ? 5'd0 : tmr_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_q   <= G1;
      tmr_q  <= LGMAX;
      cnt_q  <= LGMAX;
      lmp_q  <= LMP_G1;
      lg_q   <= 1'b0;
      pend_q <= 1'b0;
      walk_q <= 1'b0;
    end else begin
      st_q   <= st_d;
      tmr_q  <= tmr_d;
      cnt_q  <= cnt_d;
      lmp_q  <= lamp_f(st_d);
      lg_q   <= lg_d;
      pend_q <= pend_d;
      walk_q <= (st_d == WALK);
    end
  end

  assign {bus.D1, bus.V1, bus.X1,
          bus.D2, bus.V2, bus.X2} = lmp_q;
  assign bus.cnt      = cnt_q;
  assign bus.phase    = st_q;
  assign bus.ped_walk = walk_q;

endmodule

// File: tb/tb_phase_sequencer.sv
// Bench for phase_sequencer: directed scenarios plus random stimulus
// against an elapsed/remaining-ticks reference model.
module tb_phase_sequencer;

  localparam int GMIN = 5;
  localparam int GMAX = 22;
  localparam int TYEL = 2;
  localparam int TCLR = 1;
  localparam int TWLK = 6;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  phase_sequencer_if bus ();

  phase_sequencer #(
    .T_GMIN(GMIN), .T_GMAX(GMAX), .T_YEL(TYEL),
    .T_CLR(TCLR), .T_WALK(TWLK)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  bit b_r1, b_r2, b_pr, b_man, b_ms;

  // model: phase code, ticks spent in green, ticks left otherwise
  int m_ph, m_k, m_rem, m_cnt;
  bit m_pend, m_wto;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  function automatic logic [2:0] line_lamp(input int ph,
                                           input int g);
    if (ph == g) return 3'b001;
    if (ph == g + 1) return 3'b010;
    return 3'b100;
  endfunction

  task automatic m_reset();
    m_ph = 0; m_k = 0; m_rem = 0;
    m_pend = 0; m_wto = 0; m_cnt = GMAX;
  endtask

  task automatic m_enter(input int ph);
    m_ph = ph;
    m_k = 0;
    if (ph == 1 || ph == 4) m_rem = TYEL;
    else if (ph == 2 || ph == 5) m_rem = TCLR;
    else if (ph == 6) m_rem = TWLK;
    else m_rem = 0;
  endtask

  task automatic m_step(input bit tk, input bit r1,
                        input bit r2, input bit pr,
                        input bit man, input bit ms);
    bit pn, opp, ln, walked, held;
    int e;
    pn = 0;
    walked = 0;
`ifdef PED_PHASE_EN
    pn = m_pend | pr;
`endif
    if (tk) begin
      if (m_ph == 0 || m_ph == 3) begin
        ln = (m_ph == 3);
        opp = ln ? r1 : r2;
        e = (m_k + 1 < GMAX) ? m_k + 1 : GMAX;
        if (man) begin
          if (ms != ln) m_enter(ln ? 4 : 1);
        end else if (e >= GMIN && (opp || pn)) begin
          m_enter(ln ? 4 : 1);
        end else if (m_k < GMAX) begin
          m_k++;
        end
      end else if (m_rem > 1) begin
        m_rem--;
      end else begin
        case (m_ph)
          1: m_enter(2);
          4: m_enter(5);
          2, 5: begin
            ln = (m_ph == 5);
            if (man) m_enter(ms ? 3 : 0);
            else if (pn) begin
              m_wto = !ln;
              m_enter(6);
              walked = 1;
            end else m_enter(ln ? 0 : 3);
          end
          default: m_enter(m_wto ? 3 : 0);
        endcase
      end
    end
    held = man && ((m_ph == 0 && !ms) ||
                   (m_ph == 3 && ms));
    if (held) m_k = 0;
`ifdef PED_PHASE_EN
    m_pend = pr | (m_pend & !walked);
`endif
    if (held) m_cnt = 0;
    else if (m_ph == 0 || m_ph == 3)
      m_cnt = (GMAX - m_k > 1) ? GMAX - m_k : 1;
    else m_cnt = m_rem;
  endtask

  task automatic cmp_all(input string tag);
    chk({tag, ".phase"}, bus.phase, m_ph);
    chk({tag, ".cnt"}, bus.cnt, m_cnt);
    chk({tag, ".lamps"},
        {bus.D1, bus.V1, bus.X1, bus.D2, bus.V2, bus.X2},
        {line_lamp(m_ph, 0), line_lamp(m_ph, 3)});
    chk({tag, ".walk"}, bus.ped_walk, m_ph == 6);
  endtask

  task automatic cyc(input bit tk);
    bus.tick = tk;
    bus.req1 = b_r1;
    bus.req2 = b_r2;
    bus.ped_req = b_pr;
    bus.manual = b_man;
    bus.man_sel = b_ms;
    @(posedge clk);
    m_step(tk, b_r1, b_r2, b_pr, b_man, b_ms);
    @(negedge clk);
    cmp_all("cyc");
    b_pr = 0;
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      cyc(1'b1);
      cyc(1'b0);
    end
  endtask

  task automatic do_reset(input string tag);
    #2;
    reset = 1'b1;
    m_reset();
    #1;
    cmp_all(tag);
    @(posedge clk);
    @(negedge clk);
    cmp_all(tag);
    reset = 1'b0;
  endtask

  initial begin
    bus.tick = 0; bus.req1 = 0; bus.req2 = 0;
    bus.ped_req = 0; bus.manual = 0; bus.man_sel = 0;
    m_reset();
    repeat (2) @(negedge clk);
    chk("rst.phase", bus.phase, 0);
    chk("rst.cnt", bus.cnt, 22);
    chk("rst.lamps",
        {bus.D1, bus.V1, bus.X1, bus.D2, bus.V2, bus.X2},
        6'b001100);
    chk("rst.walk", bus.ped_walk, 0);
    reset = 1'b0;

    // demand on line 2 from release
    b_r2 = 1;
    ticks(4);
    chk("seq.g1", bus.phase, 0);
    ticks(1);
    chk("seq.y1", bus.phase, 1);
    ticks(2);
    chk("seq.c1", bus.phase, 2);
    ticks(1);
    chk("seq.g2", bus.phase, 3);
    chk("seq.g2cnt", bus.cnt, 22);

    // rest without demand, then demand appears
    do_reset("rst2");
    b_r2 = 0;
    ticks(40);
    chk("rest.ph", bus.phase, 0);
    chk("rest.cnt", bus.cnt, 1);
    b_r2 = 1;
    ticks(1);
    chk("rest.y1", bus.phase, 1);

    // manual override to line 2, then back to auto
    do_reset("rst3");
    b_r2 = 0;
    ticks(2);
    b_man = 1; b_ms = 1;
    ticks(1);
    chk("man.y1", bus.phase, 1);
    ticks(3);
    chk("man.g2", bus.phase, 3);
    chk("man.cnt0", bus.cnt, 0);
    ticks(10);
    chk("man.hold", bus.phase, 3);
    b_man = 0; b_r1 = 1;
    ticks(4);
    chk("auto.g2", bus.phase, 3);
    chk("auto.cnt", bus.cnt, 18);
    ticks(1);
    chk("auto.y2", bus.phase, 4);
    do_reset("rstY2");
    chk("rstY2.cnt", bus.cnt, 22);
    b_r1 = 0; b_ms = 0;

    // pedestrian pulse at tick 3 without vehicle demand
    do_reset("rst4");
    ticks(2);
    b_pr = 1;
    ticks(2);
    chk("ped.g1", bus.phase, 0);
    ticks(1);
`ifdef PED_PHASE_EN
    chk("ped.y1", bus.phase, 1);
    ticks(3);
    chk("ped.walk", bus.phase, 6);
    chk("ped.lamp", bus.ped_walk, 1);
    ticks(5);
    chk("ped.walk6", bus.phase, 6);
    ticks(1);
    chk("ped.g2", bus.phase, 3);
    chk("ped.off", bus.ped_walk, 0);
`else
    chk("noped.g1", bus.phase, 0);
    chk("noped.walk", bus.ped_walk, 0);
`endif

    // random traffic
    do_reset("rst5");
    b_r1 = 0; b_r2 = 0; b_man = 0; b_ms = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 99) < 4) b_r1 = !b_r1;
      if ($urandom_range(0, 99) < 4) b_r2 = !b_r2;
      if ($urandom_range(0, 199) < 2) b_man = !b_man;
      if ($urandom_range(0, 99) < 2) b_ms = !b_ms;
      b_pr = ($urandom_range(0, 99) < 4);
      cyc($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 599) == 0) do_reset("rrst");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/phase_sequencer.md
PHASE_SEQUENCER -- requirements
Module: phase_sequencer

Interface
REQ-001 Parameter T_GMIN, default 5, minimum green duration in ticks.
REQ-002 Parameter T_GMAX, default 22, maximum green duration in ticks when the opposing line has demand (≤31).
REQ-003 Parameter T_YEL, default 2, yellow duration in ticks.
REQ-004 Parameter T_CLR, default 1, all-red clearance duration in ticks.
REQ-005 Parameter T_WALK, default 6, pedestrian walk duration in ticks.
REQ-006 clk  in  1  system clock, the single clock of the block.
REQ-007 reset  in  1  asynchronous active-high reset.
REQ-008 tick  in  1  1 Hz single-cycle enable, synchronous to clk; all timing advances only on tick.
REQ-009 req1, req2  in  1 each  vehicle demand, line 1 and line 2, level-sensitive.
REQ-010 ped_req  in  1  pedestrian button; one-cycle or longer pulse.
REQ-011 manual  in  1  1 = manual mode, 0 = automatic mode.
REQ-012 man_sel  in  1  manual target: 0 = line 1 green, 1 = line 2 green.
REQ-013 D1,V1,X1,D2,V2,X2  out  1 each  red/yellow/green lamps, line 1 and line 2, registered.
REQ-014 cnt  out  5  remaining ticks of the current phase; 0 while a green is held.
REQ-015 phase  out  3  state code: G1=0, Y1=1, C1=2, G2=3, Y2=4, C2=5, WALK=6.
REQ-016 ped_walk  out  1  pedestrian walk lamp.

Function
REQ-017 Each state SHALL have a timer loaded on entry: G1/G2 with T_GMAX, Y with T_YEL, C with T_CLR, WALK with T_WALK. The timer SHALL decrement by 1 only on tick and saturate at 1. Non-green states SHALL exit on the tick where timer==1, so they last exactly T ticks.
REQ-018 The lamps SHALL be driven as follows. G1: X1,D2. Y1: V1,D2. C1/C2/WALK: D1,D2. G2: D1,X2. Y2: D1,V2. Exactly one lamp per line is on at all times.
REQ-019 Green exit rule (auto): the green ends (G1→Y1, G2→Y2) on a tick once elapsed = T_GMAX−timer+1 ≥ T_GMIN, and either the opposing request or ped_pend is active. If there is no opposing demand, the green SHALL rest indefinitely with timer held at 1.
REQ-020 At T_GMAX expiry with demand present, the green SHALL end on that tick regardless of its own line's request.
REQ-021 C1 SHALL go to WALK if ped_pend=1, else to G2. C2 SHALL go to WALK if ped_pend=1, else to G1. WALK SHALL exit to the green opposite the line that last had green (alternation).
REQ-022 ped_pend SHALL set on any cycle with ped_req=1. It SHALL clear on entry to WALK. A set and a clear in the same cycle SHALL leave ped_pend=1.
REQ-023 Demand sampled in the same cycle as tick SHALL count for that tick.
REQ-024 Manual: if the current green matches man_sel, the green SHALL be held with cnt=0. Otherwise the sequence SHALL proceed to Y then C immediately on the next tick, ignoring T_GMIN. After C it SHALL go directly to the selected green, skipping WALK. ped_pend is retained.
REQ-025 A man_sel change during Y or C SHALL take effect at the C exit decision.
REQ-026 When leaving manual, the held green SHALL restart its timer at T_GMAX with elapsed counting from 1.
REQ-027 cnt SHALL equal the timer in Y, C and WALK, and in an auto green. ped_walk=1 only in WALK.

Reset
REQ-028 Asynchronous assertion SHALL force, in the same cycle: phase=G1, timer=T_GMAX, X1=1, D2=1, all other lamps 0, ped_walk=0, ped_pend=0, cnt=T_GMAX.
REQ-029 Reset mid-phase SHALL abandon the phase with no yellow. Release SHALL be synchronous, and the first tick after release counts as elapsed 1.

Configuration
REQ-030 Macro PED_PHASE_EN: when defined, ped_pend and the WALK state exist as specified. When undefined, ped_req is ignored, ped_walk is tied to 0, C always goes to the opposite green, and phase code 6 is never produced.

Verification
REQ-031 Reset release with req2=1 held: G1 for 5 ticks, Y1 for 2, C1 for 1, then G2 with cnt=22.
REQ-032 req1=req2=0 after reset: G1 held for 40 ticks, cnt=1. Then raise req2: Y1 on the next tick.
REQ-033 PED_PHASE_EN defined, ped_req pulse at tick 3 in G1 with no vehicle demand: Y1 at tick 5, then C1, then WALK for 6 ticks with ped_walk=1, then G2.
REQ-034 manual=1, man_sel=1 during G1 at elapsed 2: Y1 on the next tick, C1, then G2 held with cnt=0. manual=0 with req1=1: G2 lasts 5 ticks.
REQ-035 Assert reset during Y2: lamps immediately X1=1, D2=1, cnt=22, ped_pend=0.
REQ-036 PED_PHASE_EN undefined, ped_req pulses throughout: phase never 6, ped_walk stays 0.
